// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan driver
//
// Purpose: active-low blank pattern, hex glyph table {g,f,e,d,c,b,a},
//          and a helper that sizes the digit index for a given bank width.
// Ports:   none (package).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by nibble value; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Width of the digit-index register; a single-digit bank still gets 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcdto7seg.sv
// rtl/bcdto7seg.sv - combinational hex nibble to active-low 7-segment decoder
//
// Purpose: maps a 4-bit value 0..F to its glyph.
// Ports:   digit in [3:0] nibble to show
//          seg   out [6:0] active-low segments {g,f,e,d,c,b,a}
module bcdto7seg
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[digit];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment bank driver
//
// Purpose: scans NUM_DIGITS hex digits one slot at a time with an anti-ghost
//          blank at the start of each slot, frame-aligned display updates,
//          per-digit enable, decimal points and leading-zero blanking.
// Ports:   clk, rst (sync, active-high)
//          value[4*NUM_DIGITS] / dp_in[NUM_DIGITS] captured on load
//          digit_en[NUM_DIGITS], lzb  live display controls
//          an[NUM_DIGITS], seg[7], dp  active-low registered pin drives
//          frame_done  one-cycle pulse after each frame wrap
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int TW = $clog2(DIGIT_TICKS);

  typedef logic [IW-1:0] idx_t;

  localparam idx_t          LAST_IDX  = idx_t'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(DIGIT_TICKS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..16");
  end
  if (DIGIT_TICKS < 2) begin : g_bad_digit_ticks
    $error("seg7_scan_driver: DIGIT_TICKS must be >= 2");
  end
  if (BLANK_TICKS < 0 || BLANK_TICKS >= DIGIT_TICKS) begin : g_bad_blank_ticks
    $error("seg7_scan_driver: BLANK_TICKS must be in 0..DIGIT_TICKS-1");
  end

  logic [TW-1:0]           tick_cnt;
  idx_t                    idx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_value;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic wrap;
  assign wrap = (idx == LAST_IDX) && (tick_cnt == LAST_TICK);

  // Highest digit holding a nonzero nibble; stays 0 for an all-zero value so
  // digit 0 always survives leading-zero blanking.
  idx_t top_nz;
  always_comb begin
    top_nz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (active_value[4*i +: 4] != 4'h0) top_nz = idx_t'(i);
    end
  end

  logic [3:0]            cur_nibble;
  logic [6:0]            glyph;
  logic                  blank_phase;
  logic                  dark;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_next;

  always_comb begin
    cur_nibble  = active_value[4*idx +: 4];
    blank_phase = (32'(tick_cnt) < BLANK_TICKS);
    dark        = !digit_en[idx] || (lzb && (idx > top_nz));
    lit         = !blank_phase && !dark;
    an_next     = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  bcdto7seg u_dec (
    .digit (cur_nibble),
    .seg   (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      an           <= '1;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      if (tick_cnt == LAST_TICK) begin
        tick_cnt <= '0;
        idx      <= (idx == LAST_IDX) ? '0 : idx + idx_t'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      // On a load that lands on the wrap cycle, active still takes the old shadow.
      if (wrap) begin
        active_value <= shadow_value;
        active_dp    <= shadow_dp;
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
      end

      an         <= an_next;
      seg        <= lit ? glyph : SEG_BLANK;
      dp         <= lit ? ~active_dp[idx] : 1'b1;
      frame_done <= wrap;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a parametrised bank of common-anode 7-segment hex digits. It captures a packed hex value, scans one digit at a time at a programmable per-digit rate and decodes each nibble to active-low segments. It adds per-digit enable, decimal points, optional leading-zero blanking, anti-ghost blanking and tear-free frame-aligned updates. It sits between the counter/datapath logic and the board's shared segment/anode pins.

## Interface
- NUM_DIGITS, 8: digits in the bank, legal range 1..16.
- DIGIT_TICKS, 100_000: clk cycles per digit slot, must be ≥ 2.
- BLANK_TICKS, 1000: cycles at the start of each slot with all anodes off, 0 ≤ BLANK_TICKS < DIGIT_TICKS.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit may light; 0 = digit is forced dark.
- lzb  in  1  leading-zero blanking enable.
- load  in  1  one-cycle strobe; captures value and dp_in into the shadow register.
- an  out  NUM_DIGITS  active-low anode selects.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at every frame wrap.

## Operation
- State: tick_cnt (0..DIGIT_TICKS-1), idx (0..NUM_DIGITS-1), shadow {value, dp}, active {value, dp}.
- tick_cnt increments every cycle. At DIGIT_TICKS-1 it returns to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- On the wrap cycle (idx = NUM_DIGITS-1 and tick_cnt = DIGIT_TICKS-1):
  - active ← shadow.
  - frame_done = 1 in the following cycle.
- load: shadow ← {value, dp_in}. If load coincides with the wrap cycle, active takes the old shadow and the new data appears one frame later.
- Slot phases:
  - tick_cnt < BLANK_TICKS: blank phase. an is all 1, seg = 7'h7F, dp = 1.
  - Otherwise: lit phase. an[idx] = 0 unless digit idx is dark.
- Digit idx is dark when digit_en[idx] = 0, or when lzb = 1 and idx > the highest index holding a nonzero nibble in active.
- Digit 0 is never blanked by lzb. An all-zero value shows a single "0".
- lzb uses active only and ignores digit_en.
- A dark digit drives an all 1, seg = 7'h7F, dp = 1.
- Decode is hex 0–F to standard glyphs (0 = 7'b1000000, A = 7'b0001000, F = 7'b0001110).
- dp = ~active.dp[idx] during the lit phase.

## Timing
- an, seg, dp and frame_done are registered. Their value at cycle t+1 is a function of (idx, tick_cnt, active, lzb, digit_en) at cycle t. This is a 1-cycle latency.
- Frame period is NUM_DIGITS × DIGIT_TICKS cycles.
- Reset values:
  - tick_cnt = 0, idx = 0.
  - shadow = 0, active = 0.
  - an = all 1, seg = 7'h7F, dp = 1, frame_done = 0.
- The first lit output appears BLANK_TICKS+1 cycles after rst deasserts, with BLANK_TICKS > 0.
- rst mid-frame returns to the reset state on the next edge. No partial digit is held.
- lzb and digit_en are sampled live each cycle and are not frame-aligned.

## Structure
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F.
  - hex glyph constants.
  - digit-index type sized $clog2(NUM_DIGITS) (min 1).
- Sub-module: the existing bcdto7seg decoder, one instance, combinational. Its output feeds the seg register.
- Leading-nonzero detect is a priority encoder in the top module.
- Elaboration-time assertions check the parameter legality rules.

## Test plan
Bench parameters: NUM_DIGITS=4, DIGIT_TICKS=4, BLANK_TICKS=1.
- Reset, then load value=16'h12AF, dp_in=0, digit_en=4'hF, lzb=0:
  - Frame after load shows an 1110/seg 0001110, then 1101/0001000, 1011/0100100, 0111/1111001.
  - Each slot has 1 blank cycle then 3 lit cycles.
  - frame_done pulses every 16 cycles.
- load 16'h0050 with lzb=1:
  - Digits 3 and 2 are dark (an all 1, seg 7'h7F).
  - Digit 1 shows "5", digit 0 shows "0".
  - value 16'h0000 with lzb=1 shows only digit 0 = "0".
- load in mid-frame:
  - Current frame keeps the old digits.
  - New value appears from the first slot after frame_done.
  - load asserted exactly on the wrap cycle appears one frame later.
- digit_en=4'b0101, dp_in=4'b0010:
  - Digits 1 and 3 are never selected.
  - dp stays 1 throughout, since digit 1 is disabled.
  - With digit_en=4'hF, dp = 0 only while an = 1101.
- Assert rst during digit 2's lit phase:
  - Next cycle: an all 1, seg 7'h7F, frame_done 0.
  - Scan restarts at digit 0.
  - Shadow is cleared, so an all-zero display follows.
